push_debounce_sync: RTL and testbench



---
 rtl/push_debounce_sync.sv | 62 ++++++
 tb/tb_push_debounce_sync.sv | 92 +++++++++
 2 files changed

// File: rtl/push_debounce_sync.sv
// push_debounce_sync: two-flop synchroniser plus per-channel counter debounce with press/release pulses.
module push_debounce_sync #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W = 17
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic [3:0] btn_in,
    output logic [3:0] push_level,
    output logic [3:0] press_pulse,
    output logic [3:0] release_pulse
);
    // Encoding: bit1 = settled level, bit0 = checking for a change away from it
    typedef enum logic [1:0] {S_LOW = 2'b00, S_CHK_H = 2'b01, S_HIGH = 2'b10, S_CHK_L = 2'b11} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [3:0] s1, s2;
    always_ff @(posedge pclk) begin
        if (preset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_in;
            s2 <= s1;
        end
    end
    for (genvar g = 0; g < 4; g++) begin : ch
        state_t state, state_nxt;
        logic [CNT_W-1:0] cnt, cnt_nxt;
        logic lvl, prs, rel, lvl_nxt, prs_nxt, rel_nxt, want, hit, chk, acc;
        always_ff @(posedge pclk) begin
            if (preset) begin
                state <= S_LOW;
                cnt   <= '0;
                lvl   <= 1'b0;
                prs   <= 1'b0;
                rel   <= 1'b0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                lvl   <= lvl_nxt;
                prs   <= prs_nxt;
                rel   <= rel_nxt;
            end
        end
        always_comb begin
            want = ~state[1];
            hit  = s2[g] == want;
            chk  = state[0];
            acc  = chk && hit && cnt == LAST;
            state_nxt = !hit ? state_t'({state[1], 1'b0}) : acc ? state_t'({~state[1], 1'b0}) : state_t'({state[1], 1'b1});
            cnt_nxt = (!hit || acc) ? '0 : chk ? cnt + 1'b1 : CNT_W'(1);
        end
        always_comb begin
            lvl_nxt = acc ? ~lvl : lvl;
            prs_nxt = acc & want;
            rel_nxt = acc & ~want;
        end
        assign push_level[g]    = lvl;
        assign press_pulse[g]   = prs;
        assign release_pulse[g] = rel;
    end
endmodule

// File: tb/tb_push_debounce_sync.sv
// tb_push_debounce_sync: table-driven checks of push_debounce_sync with DEBOUNCE_CYCLES=8.
module tb_push_debounce_sync;
    logic pclk = 1'b0, preset = 1'b1;
    logic [3:0] btn_in = 4'h0, push_level, press_pulse, release_pulse;
    int total = 0, bad = 0;
    typedef struct {
        logic       rst;
        logic [3:0] btn;
        int         n;
        logic [3:0] lvl, prs, rel;
    } vec_t;
    vec_t tbl[$];
    push_debounce_sync #(.DEBOUNCE_CYCLES(8), .CNT_W(4)) dut (
        .pclk(pclk), .preset(preset), .btn_in(btn_in),
        .push_level(push_level), .press_pulse(press_pulse), .release_pulse(release_pulse)
    );
    always #5 pclk = ~pclk;
    task automatic check(input string name, input logic [11:0] exp);
        total++;
        if ({push_level, press_pulse, release_pulse} !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got lvl/prs/rel=%h want %h", name, $time,
                     {push_level, press_pulse, release_pulse}, exp);
        end
    endtask
    task automatic step(input logic r, input logic [3:0] b);
        preset = r;
        btn_in = b;
        @(posedge pclk);
        @(negedge pclk);
    endtask
    initial begin
        int k;
        // each row holds its inputs for n edges; outputs must match after every one
        tbl.push_back('{1'b1, 4'hF, 3, 4'h0, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'h1, 9, 4'h0, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'h1, 1, 4'h1, 4'h1, 4'h0});
        tbl.push_back('{1'b0, 4'h1, 5, 4'h1, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'h3, 5, 4'h1, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'h1, 2, 4'h1, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'h3, 7, 4'h1, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'h1, 10, 4'h1, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'h0, 9, 4'h1, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'h0, 1, 4'h0, 4'h0, 4'h1});
        tbl.push_back('{1'b0, 4'h0, 4, 4'h0, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'hA, 9, 4'h0, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'hA, 1, 4'hA, 4'hA, 4'h0});
        tbl.push_back('{1'b0, 4'hA, 3, 4'hA, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'h0, 9, 4'hA, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'h0, 1, 4'h0, 4'h0, 4'hA});
        tbl.push_back('{1'b0, 4'h0, 3, 4'h0, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'h8, 7, 4'h0, 4'h0, 4'h0});
        tbl.push_back('{1'b1, 4'h8, 1, 4'h0, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'h8, 9, 4'h0, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'h8, 1, 4'h8, 4'h8, 4'h0});
        tbl.push_back('{1'b0, 4'h8, 2, 4'h8, 4'h0, 4'h0});
        @(negedge pclk);
        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].n; c++) begin
                step(tbl[i].rst, tbl[i].btn);
                check($sformatf("row%0d.c%0d", i, c), {tbl[i].lvl, tbl[i].prs, tbl[i].rel});
            end
        end
        // press latency on channel 2, counted in edges including the capture edge
        k = 0;
        do begin
            step(1'b0, 4'hC);
            k++;
        end while (press_pulse[2] !== 1'b1 && k < 30);
        total++;
        if (k != 10) begin
            bad++;
            $display("FAIL press2_latency got %0d edges want 10", k);
        end
        check("press2_pulse", {4'hC, 4'h4, 4'h0});
        step(1'b0, 4'hC);
        check("press2_one_cycle", {4'hC, 4'h0, 4'h0});
        // reset on the edge that would accept the release must suppress its pulse
        for (int c = 0; c < 9; c++) begin
            step(1'b0, 4'h0);
            check($sformatf("rel_wait.c%0d", c), {4'hC, 4'h0, 4'h0});
        end
        step(1'b1, 4'h0);
        check("reset_wins", 12'h000);
        for (int c = 0; c < 12; c++) begin
            step(1'b0, 4'h0);
            check($sformatf("post_reset_idle.c%0d", c), 12'h000);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
